// File: rtl/otp_keystream_gen.sv
// otp_keystream_gen
// ------------------------------------------------------------------------
// Keystream source for the one-time-pad encryptor. A 32-bit seed arrives
// one byte per seed_we strobe, least significant byte first. A valid seed
// starts a stream of pad bytes from a 32-bit Galois LFSR. The LFSR advances
// eight steps for every byte the downstream XOR stage accepts. After PAD_LEN
// accepted bytes the block locks out until it is reseeded, so a pad is never
// reused silently.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high
//   seed_we    : seed byte write strobe (one byte per cycle)
//   seed_byte  : seed byte, little-endian (first write -> seed[7:0])
//   ks_ready   : downstream ready for a keystream byte
//   ks_valid   : ks_byte is valid
//   ks_byte    : current keystream byte (low byte of the LFSR)
//   keyed      : high while a stream is running
//   exhausted  : PAD_LEN bytes consumed; a reseed is required
//   seed_err   : last completed seed was all-zero (sticky until next seed_we)
//   bytes_used : bytes consumed since the last valid seed
module otp_keystream_gen #(
    parameter int          PAD_LEN   = 256,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_MASK = 32'h80200003
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [7:0]       seed_byte,
    input  logic             ks_ready,
    output logic             ks_valid,
    output logic [7:0]       ks_byte,
    output logic             keyed,
    output logic             exhausted,
    output logic             seed_err,
    output logic [CNT_W-1:0] bytes_used
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_EXHAUSTED
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [31:0]        seed_q, seed_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seed_err_q, seed_err_d;

    logic [31:0]        seed_wr;
    logic [CNT_W-1:0]   cnt_inc;

    // Eight Galois steps unrolled so that one full byte is produced per
    // accepted handshake. This keeps throughput at one byte per cycle.
    function automatic logic [31:0] lfsr_adv8(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        for (int i = 0; i < 8; i++) begin
            if (s[0]) begin
                s = (s >> 1) ^ LFSR_MASK;
            end else begin
                s = s >> 1;
            end
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            seed_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_q     <= seed_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seed_err_q <= seed_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_d     = seed_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seed_err_d = seed_err_q;

        // The seed as it looks with the incoming byte merged in. On the
        // fourth write this is the complete seed, checked in the same cycle.
        seed_wr = seed_q;
        seed_wr[{idx_q, 3'b000} +: 8] = seed_byte;
        cnt_inc = cnt_q + CNT_W'(1);

        // A seed write takes priority over a handshake in any state. This
        // aborts a running stream without counting the concurrent transfer.
        if (seed_we) begin
            seed_d     = seed_wr;
            seed_err_d = 1'b0;
            if (idx_q == 2'd3) begin
                idx_d = 2'd0;
                if (seed_wr == 32'd0) begin
                    // A zero seed would lock the LFSR at zero, so reject it.
                    seed_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    lfsr_d  = seed_wr;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end else begin
                idx_d   = idx_q + 2'd1;
                state_d = S_LOAD;
            end
        end else if (state_q == S_RUN && ks_ready) begin
            lfsr_d = lfsr_adv8(lfsr_q);
            cnt_d  = cnt_inc;
            if (cnt_inc == CNT_W'(PAD_LEN)) begin
                state_d = S_EXHAUSTED;
            end
        end
    end

    assign ks_valid   = (state_q == S_RUN);
    assign keyed      = (state_q == S_RUN);
    assign exhausted  = (state_q == S_EXHAUSTED);
    assign seed_err   = seed_err_q;
    assign ks_byte    = lfsr_q[7:0];
    assign bytes_used = cnt_q;

endmodule

// File: tb/tb_otp_keystream_gen.sv
// tb_otp_keystream_gen
// ------------------------------------------------------------------------
// Self-checking bench for otp_keystream_gen, built with a short pad
// (PAD_LEN = 4) so that exhaustion is reached quickly. A reference model
// holds the seed being assembled, the pad state, the consumed count and
// the status flags. It is updated from the protocol rules for each cycle
// the bench drives.
module tb_otp_keystream_gen;

    localparam int          PAD_LEN = 4;
    localparam int          CNT_W   = 16;
    localparam logic [31:0] MASK    = 32'h80200003;

    logic             clk;
    logic             rst;
    logic             seed_we;
    logic [7:0]       seed_byte;
    logic             ks_ready;
    logic             ks_valid;
    logic [7:0]       ks_byte;
    logic             keyed;
    logic             exhausted;
    logic             seed_err;
    logic [CNT_W-1:0] bytes_used;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_buf [4];
    int          m_idx;
    logic [31:0] m_pad;
    int          m_cnt;
    bit          m_run;
    bit          m_exh;
    bit          m_err;

    otp_keystream_gen #(
        .PAD_LEN   (PAD_LEN),
        .CNT_W     (CNT_W),
        .LFSR_MASK (MASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_we    (seed_we),
        .seed_byte  (seed_byte),
        .ks_ready   (ks_ready),
        .ks_valid   (ks_valid),
        .ks_byte    (ks_byte),
        .keyed      (keyed),
        .exhausted  (exhausted),
        .seed_err   (seed_err),
        .bytes_used (bytes_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the pad by one byte: eight single-bit Galois shifts
    function automatic logic [31:0] next_pad(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        for (int i = 0; i < 8; i++) begin
            s = (s >> 1) ^ (((s % 2) == 1) ? MASK : 32'd0);
        end
        return s;
    endfunction

    // Compare one observed value against the model/constant expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model
    task automatic checkAll(input string tag);
        checkOutput({tag, ".ks_valid"},   32'(ks_valid),   32'(m_run));
        checkOutput({tag, ".keyed"},      32'(keyed),      32'(m_run));
        checkOutput({tag, ".exhausted"},  32'(exhausted),  32'(m_exh));
        checkOutput({tag, ".seed_err"},   32'(seed_err),   32'(m_err));
        checkOutput({tag, ".bytes_used"}, 32'(bytes_used), 32'(m_cnt));
        if (m_run) begin
            checkOutput({tag, ".ks_byte"}, 32'(ks_byte), 32'(m_pad[7:0]));
        end
    endtask

    // Drive one cycle of inputs, apply the same edge to the model, then
    // sample the outputs 1 time unit after the rising edge
    task automatic applyStimulus(input bit we, input logic [7:0] b, input bit rdy,
                                 input string tag);
        logic [31:0] seed;
        seed_we   = we;
        seed_byte = b;
        ks_ready  = rdy;
        if (we) begin
            m_buf[m_idx] = b;
            m_idx++;
            m_run = 0;
            m_exh = 0;
            m_err = 0;
            if (m_idx == 4) begin
                m_idx = 0;
                seed  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                if (seed == 0) begin
                    m_err = 1;
                end else begin
                    m_pad = seed;
                    m_cnt = 0;
                    m_run = 1;
                end
            end
        end else if (m_run && rdy) begin
            m_pad = next_pad(m_pad);
            m_cnt++;
            if (m_cnt == PAD_LEN) begin
                m_run = 0;
                m_exh = 1;
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic doReset(input int ncyc);
        rst       = 1'b1;
        seed_we   = 1'b0;
        seed_byte = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
        end
        #1;
        rst   = 1'b0;
        m_idx = 0;
        m_pad = 0;
        m_cnt = 0;
        m_run = 0;
        m_exh = 0;
        m_err = 0;
        for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
        checkAll("reset");
        checkOutput("reset.ks_byte", 32'(ks_byte), 32'h0);
    endtask

    // Four seed writes, LSB first, with up to maxgap idle cycles before each
    task automatic loadSeed(input logic [31:0] seed, input int maxgap, input bit rdy);
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00, rdy, "gap");
            applyStimulus(1'b1, seed[8*i +: 8], rdy, "load");
        end
    endtask

    initial begin
        logic [31:0] rs;
        seed_we   = 1'b0;
        seed_byte = 8'h00;
        ks_ready  = 1'b0;
        rst       = 1'b0;

        // Power-on reset
        doReset(2);

        // Seed 0x00000001 with gaps; the first bytes are 0x01 then 0x02
        loadSeed(32'h00000001, 3, 1'b1);
        checkOutput("seed1.first_byte", 32'(ks_byte), 32'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, "xfer1");
        checkOutput("seed1.second_byte", 32'(ks_byte), 32'h02);
        checkOutput("seed1.bytes_used", 32'(bytes_used), 32'd1);

        // Backpressure: the byte and the count hold while ks_ready is low
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, "stall");
            checkOutput("stall.ks_byte", 32'(ks_byte), 32'h02);
            checkOutput("stall.bytes_used", 32'(bytes_used), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, "release");
        checkOutput("release.ks_byte", 32'(ks_byte), 32'(next_pad(32'hDB36C002) & 32'hFF));

        // Drain to exhaustion, then confirm that ks_ready is ignored
        applyStimulus(1'b0, 8'h00, 1'b1, "xfer3");
        applyStimulus(1'b0, 8'h00, 1'b1, "xfer4");
        checkOutput("exh.exhausted", 32'(exhausted), 32'd1);
        checkOutput("exh.bytes_used", 32'(bytes_used), 32'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, "exh_hold");

        // Reseed after exhaustion restarts the stream at 0x01
        loadSeed(32'h00000001, 0, 1'b0);
        checkOutput("reseed.ks_byte", 32'(ks_byte), 32'h01);
        checkOutput("reseed.exhausted", 32'(exhausted), 32'd0);

        // Zero seed is rejected; the next write clears seed_err
        loadSeed(32'h00000000, 2, 1'b1);
        checkOutput("zero.seed_err", 32'(seed_err), 32'd1);
        checkOutput("zero.ks_valid", 32'(ks_valid), 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b1, "zero_clear");
        checkOutput("zero_clear.seed_err", 32'(seed_err), 32'd0);
        applyStimulus(1'b1, 8'h00, 1'b1, "load");
        applyStimulus(1'b1, 8'h00, 1'b1, "load");
        applyStimulus(1'b1, 8'h00, 1'b1, "load");
        checkOutput("zero_clear.ks_byte", 32'(ks_byte), 32'h5A);

        // Abort: a seed write on a transfer edge wins, and the count is frozen
        applyStimulus(1'b0, 8'h00, 1'b1, "pre_abort");
        applyStimulus(1'b1, 8'hAA, 1'b1, "abort");
        checkOutput("abort.bytes_used", 32'(bytes_used), 32'd1);
        checkOutput("abort.ks_valid", 32'(ks_valid), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, "abort_idle");
        applyStimulus(1'b1, 8'h11, 1'b1, "abort_load");
        applyStimulus(1'b1, 8'h22, 1'b1, "abort_load");
        applyStimulus(1'b1, 8'h33, 1'b1, "abort_load");
        checkOutput("abort.resume_byte", 32'(ks_byte), 32'hAA);

        // Reset mid-run and mid-load, then a clean load
        applyStimulus(1'b0, 8'h00, 1'b1, "pre_rst");
        doReset(2);
        applyStimulus(1'b1, 8'h77, 1'b0, "part");
        applyStimulus(1'b1, 8'h66, 1'b0, "part");
        doReset(1);
        loadSeed(32'hCAFE0042, 1, 1'b0);
        checkOutput("post_rst.ks_byte", 32'(ks_byte), 32'h42);

        // Randomised streams with random backpressure, bounded by a cycle budget
        for (int r = 0; r < 4; r++) begin
            int budget;
            rs = $urandom;
            if (rs == 0) rs = 32'h1;
            loadSeed(rs, 2, 1'b0);
            budget = 0;
            while (!m_exh && budget < 60) begin
                applyStimulus(1'b0, 8'h00, bit'($urandom_range(0, 1)), "rand");
                budget++;
            end
            checkOutput("rand.reached_exhaustion", 32'(m_exh), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otp_keystream_gen.md
Name: otp_keystream_gen

Overview:
Keystream source for the one-time-pad encryptor datapath; sits directly upstream of the encryptor's XOR stage and supplies one pad byte per accepted handshake. A 32-bit seed is loaded bytewise from the host pins. Bytes are generated by a maximal-length 32-bit Galois LFSR advanced 8 steps per byte. The block enforces a pad-length budget so the same pad is never silently reused.

Parameters:
PAD_LEN, 256, number of keystream bytes issued per seed before exhaustion (1..65535)
CNT_W, 16, width of the issued-byte counter; must satisfy 2^CNT_W > PAD_LEN
LFSR_MASK, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
seed_we  input  1  seed byte write strobe, one byte per cycle
seed_byte  input  8  seed byte, little-endian (first write -> seed[7:0])
ks_ready  input  1  encryptor ready to consume keystream byte
ks_valid  output  1  ks_byte valid
ks_byte  output  8  current keystream byte
keyed  output  1  high while in RUN
exhausted  output  1  PAD_LEN bytes consumed; reseed required
seed_err  output  1  last completed seed was all-zero (sticky until next seed_we)
bytes_used  output  CNT_W  bytes consumed since last valid seed

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, LFSR=0, seed shift register=0, write index=0, counter=0; ks_valid=0, ks_byte=0, keyed=0, exhausted=0, seed_err=0, bytes_used=0. Reset overrides all other inputs in the same cycle, including mid-load and mid-run.
- States: IDLE, LOAD, RUN, EXHAUSTED.
- Any state, seed_we=1: byte stored at seed[8*idx +: 8], idx increments, state becomes LOAD; seed_err clears; ks_valid, keyed and exhausted drop on the next edge. A write during RUN aborts the stream with no further bytes issued.
- LOAD: the 4th write (idx==3) completes the seed and idx wraps to 0. If the assembled seed == 0: seed_err=1, state=IDLE. Otherwise LFSR=seed, counter=0, state=RUN.
- Seed arrival rate: writes need not be back-to-back. Gaps with seed_we=0 hold the partial seed indefinitely.
- RUN: ks_valid=1 and keyed=1 registered, asserted the cycle after the completing write. ks_byte = LFSR[7:0] (combinational from the state register).
- Handshake: a transfer occurs on an edge where ks_valid && ks_ready. On a transfer:
  - LFSR advances 8 Galois steps in one cycle. Each step: b=s[0]; s=s>>1; if b then s^=LFSR_MASK.
  - The counter increments.
- ks_byte is stable while ks_valid && !ks_ready. No bubble between consecutive transfers: throughput is 1 byte/cycle.
- Transfer that makes counter==PAD_LEN: state=EXHAUSTED next edge; ks_valid=0, keyed=0, exhausted=1. bytes_used holds PAD_LEN. ks_ready is ignored outside RUN.
- Simultaneous seed_we and transfer in RUN: the seed write wins and the transfer does not count (LFSR is not advanced).
- seed_err and exhausted are mutually exclusive. Both clear on the first seed_we.
- LFSR never reaches 0 from a nonzero seed. No lockup handling is needed beyond the zero-seed rejection.

Test Plan:
- Reset: assert rst for 2 cycles mid-RUN -> all outputs 0, state IDLE; a following 4-byte load works normally.
- Load seed bytes 01,00,00,00 with gaps between writes, hold ks_ready=1 -> ks_valid rises 1 cycle after 4th write; ks_byte sequence 0x01 then 0x02; LFSR=0xDB36C002 after first transfer; bytes_used=1.
- Backpressure: ks_ready=0 for 5 cycles in RUN -> ks_byte/ks_valid constant, bytes_used unchanged; release -> next byte matches the no-stall sequence.
- Zero seed: write 00,00,00,00 -> seed_err=1, ks_valid=0, keyed=0; next seed_we -> seed_err=0.
- Exhaustion, PAD_LEN=4, ks_ready=1 -> exactly 4 transfers, then exhausted=1, ks_valid=0, bytes_used=4; reseed with 01,00,00,00 -> stream restarts at 0x01 and exhausted clears.
- Abort: seed_we on the same edge as a transfer in RUN -> bytes_used not incremented, ks_valid=0 next cycle, new 4-byte load required before output resumes.
